// File: rtl/slave_rx_port_if.sv
// Bus bundle between a serial master and slave_rx_port: handshake, serial
// header/data lines and the registered beat outputs.
interface slave_rx_port_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  master_valid;
  logic                  read_en;
  logic                  write_en;
  logic                  rx_address;
  logic                  rx_burst;
  logic                  rx_data;
  logic                  slave_ready;
  logic                  rx_done;
  logic                  rx_write;
  logic                  rx_last;
  logic                  rx_err;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data;

  modport master (
    output master_valid, read_en, write_en, rx_address, rx_burst, rx_data,
    input  slave_ready, rx_done, rx_write, rx_last, rx_err, address, data
  );

  modport slave (
    input  master_valid, read_en, write_en, rx_address, rx_burst, rx_data,
    output slave_ready, rx_done, rx_write, rx_last, rx_err, address, data
  );
endinterface

// File: rtl/slave_rx_port.sv
// Serial slave receive port: handshake, LSB-first header deserialisation
// (address + burst length), then one strobe per read beat or per received
// write word, with auto-incrementing address and abort on master_valid drop.
module slave_rx_port #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned BURST_WIDTH = 8
) (
  input logic            clk,
  input logic            reset,
  slave_rx_port_if.slave bus
);
  localparam int unsigned HdrLen = (ADDR_WIDTH > BURST_WIDTH) ? ADDR_WIDTH : BURST_WIDTH;
  localparam int unsigned HCW    = $clog2(HdrLen + 1);
  localparam int unsigned DCW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned BCW    = BURST_WIDTH + 1;

  localparam logic [HCW-1:0] HdrLast  = HCW'(HdrLen - 1);
  localparam logic [HCW-1:0] AddrLim  = HCW'(ADDR_WIDTH);
  localparam logic [HCW-1:0] BurstLim = HCW'(BURST_WIDTH);
  localparam logic [DCW-1:0] BitLast  = DCW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StHeader, StWdata, StRbeat} state_e;

  state_e                 state_q, state_d;
  logic [HCW-1:0]         hdr_cnt_q, hdr_cnt_d;
  logic [DCW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0]         beat_q, beat_d;
  // Header shift register, reused as the running beat address afterwards.
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BURST_WIDTH-1:0] burst_q, burst_d;
  logic [DATA_WIDTH-1:0]  wsh_q, wsh_d;
  logic                   is_write_q, is_write_d;

  logic                   slave_ready_q, slave_ready_d;
  logic                   rx_done_q, rx_done_d;
  logic                   rx_write_q, rx_write_d;
  logic                   rx_last_q, rx_last_d;
  logic                   rx_err_q, rx_err_d;
  logic [ADDR_WIDTH-1:0]  address_q, address_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;

  logic                   handshake, abort, hdr_sample, dir, beat_last;
  logic [HCW-1:0]         hdr_idx;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d       = state_q;
    hdr_cnt_d     = hdr_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    beat_d        = beat_q;
    addr_d        = addr_q;
    burst_d       = burst_q;
    wsh_d         = wsh_q;
    is_write_d    = is_write_q;
    rx_done_d     = 1'b0;
    rx_write_d    = 1'b0;
    rx_last_d     = 1'b0;
    rx_err_d      = 1'b0;
    address_d     = address_q;
    data_d        = data_q;
    dir           = is_write_q;
    beat_last     = (beat_q == {1'b0, burst_q});

    handshake  = slave_ready_q && bus.master_valid && (bus.read_en ^ bus.write_en);
    abort      = (state_q != StIdle) && !bus.master_valid;
    hdr_sample = handshake || (state_q == StHeader);
    hdr_idx    = handshake ? '0 : hdr_cnt_q;

    if (abort) begin
      state_d  = StIdle;
      rx_err_d = 1'b1;
    end else if (hdr_sample) begin
      // The handshake cycle already carries header bit 0.
      if (handshake) begin
        is_write_d = bus.write_en;
        dir        = bus.write_en;
      end
      if (hdr_idx < AddrLim) begin
        addr_d = (addr_q >> 1) | (ADDR_WIDTH'(bus.rx_address) << (ADDR_WIDTH - 1));
      end
      if (hdr_idx < BurstLim) begin
        burst_d = (burst_q >> 1) | (BURST_WIDTH'(bus.rx_burst) << (BURST_WIDTH - 1));
      end
      hdr_cnt_d = hdr_idx + HCW'(1);
      state_d   = StHeader;
      if (hdr_idx == HdrLast) begin
        beat_d    = '0;
        bit_cnt_d = '0;
        if (dir) begin
          state_d = StWdata;
        end else begin
          // Read beat 0 goes out straight off the last header bit.
          rx_done_d = 1'b1;
          address_d = addr_d;
          rx_last_d = (burst_d == '0);
          if (burst_d == '0) begin
            state_d = StIdle;
          end else begin
            state_d = StRbeat;
            addr_d  = addr_d + ADDR_WIDTH'(1);
            beat_d  = BCW'(1);
          end
        end
      end
    end else if (state_q == StWdata) begin
      wsh_d = (wsh_q >> 1) | (DATA_WIDTH'(bus.rx_data) << (DATA_WIDTH - 1));
      if (bit_cnt_q == BitLast) begin
        bit_cnt_d  = '0;
        rx_done_d  = 1'b1;
        rx_write_d = 1'b1;
        rx_last_d  = beat_last;
        data_d     = wsh_d;
        address_d  = addr_q;
        if (beat_last) begin
          state_d = StIdle;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          beat_d = beat_q + BCW'(1);
        end
      end else begin
        bit_cnt_d = bit_cnt_q + DCW'(1);
      end
    end else if (state_q == StRbeat) begin
      rx_done_d = 1'b1;
      rx_last_d = beat_last;
      address_d = addr_q;
      if (beat_last) begin
        state_d = StIdle;
      end else begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        beat_d = beat_q + BCW'(1);
      end
    end

    slave_ready_d = (state_d == StIdle);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      hdr_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      beat_q        <= '0;
      addr_q        <= '0;
      burst_q       <= '0;
      wsh_q         <= '0;
      is_write_q    <= 1'b0;
      slave_ready_q <= 1'b1;
      rx_done_q     <= 1'b0;
      rx_write_q    <= 1'b0;
      rx_last_q     <= 1'b0;
      rx_err_q      <= 1'b0;
      address_q     <= '0;
      data_q        <= '0;
    end else begin
      state_q       <= state_d;
      hdr_cnt_q     <= hdr_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      beat_q        <= beat_d;
      addr_q        <= addr_d;
      burst_q       <= burst_d;
      wsh_q         <= wsh_d;
      is_write_q    <= is_write_d;
      slave_ready_q <= slave_ready_d;
      rx_done_q     <= rx_done_d;
      rx_write_q    <= rx_write_d;
      rx_last_q     <= rx_last_d;
      rx_err_q      <= rx_err_d;
      address_q     <= address_d;
      data_q        <= data_d;
    end
  end

  assign bus.slave_ready = slave_ready_q;
  assign bus.rx_done     = rx_done_q;
  assign bus.rx_write    = rx_write_q;
  assign bus.rx_last     = rx_last_q;
  assign bus.rx_err      = rx_err_q;
  assign bus.address     = address_q;
  assign bus.data        = data_q;
endmodule

// File: tb/tb_slave_rx_port.sv
// Scoreboard bench for slave_rx_port: a default 12/8/8 instance and a
// 16/32/4 instance share one serial driver; sel picks the active one.
module tb_slave_rx_port;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mv = 1'b0, ren = 1'b0, wen = 1'b0, ra = 1'b0, rb = 1'b0, rd = 1'b0;
  logic sel = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   aw = 12, dw = 8, bw = 8;
  bit   mon_en = 1'b0;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [31:0] data;
    bit          wr;
    bit          last;
  } exp_t;

  exp_t        exp_q[$];
  int          err_q[$];
  exp_t        mon_e;
  logic [31:0] wd [0:15];

  slave_rx_port_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8))  if_a ();
  slave_rx_port_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) if_b ();

  slave_rx_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .BURST_WIDTH(8)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a.slave)
  );

  slave_rx_port #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .BURST_WIDTH(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b.slave)
  );

  assign if_a.master_valid = mv && !sel;
  assign if_b.master_valid = mv && sel;
  assign if_a.read_en      = ren;
  assign if_b.read_en      = ren;
  assign if_a.write_en     = wen;
  assign if_b.write_en     = wen;
  assign if_a.rx_address   = ra;
  assign if_b.rx_address   = ra;
  assign if_a.rx_burst     = rb;
  assign if_b.rx_burst     = rb;
  assign if_a.rx_data      = rd;
  assign if_b.rx_data      = rd;

  logic        m_ready, m_done, m_write, m_last, m_err;
  logic [15:0] m_addr;
  logic [31:0] m_data;

  always_comb begin
    if (!sel) begin
      m_ready = if_a.slave_ready;
      m_done  = if_a.rx_done;
      m_write = if_a.rx_write;
      m_last  = if_a.rx_last;
      m_err   = if_a.rx_err;
      m_addr  = 16'(if_a.address);
      m_data  = 32'(if_a.data);
    end else begin
      m_ready = if_b.slave_ready;
      m_done  = if_b.rx_done;
      m_write = if_b.rx_write;
      m_last  = if_b.rx_last;
      m_err   = if_b.rx_err;
      m_addr  = if_b.address;
      m_data  = if_b.data;
    end
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: strobes are compared against queued expectations.
  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check_eq("missing_done", 32'(exp_q[0].cyc), 32'(cyc));
        void'(exp_q.pop_front());
      end
      while (err_q.size() > 0 && err_q[0] < cyc) begin
        check_eq("missing_err", 32'(err_q[0]), 32'(cyc));
        void'(err_q.pop_front());
      end
      if (m_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_done", 32'(m_done), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("done_cycle", 32'(cyc), 32'(mon_e.cyc));
          check_eq("addr", 32'(m_addr), 32'(mon_e.addr));
          check_eq("write", 32'(m_write), 32'(mon_e.wr));
          check_eq("last", 32'(m_last), 32'(mon_e.last));
          if (mon_e.wr) check_eq("data", m_data, mon_e.data);
        end
      end
      if (m_err === 1'b1) begin
        if (err_q.size() == 0) begin
          check_eq("unexpected_err", 32'(m_err), 32'd0);
        end else begin
          check_eq("err_cycle", 32'(cyc), 32'(err_q.pop_front()));
        end
      end
    end
  end

  // Drives one transaction starting in the current cycle (T0) and queues its
  // expected beats; abort_off / reset_off (>= 0) cut it short at T0+offset.
  task automatic do_txn(input bit wr, input int n, input logic [15:0] base,
                        input int abort_off, input int reset_off);
    int          h, len, t0, stop, cut, k, j;
    logic [15:0] nb;
    logic [15:0] amask;
    exp_t        e;
    h     = (aw > bw) ? aw : bw;
    len   = wr ? h + (n + 1) * dw : h + n;
    amask = 16'((32'd1 << aw) - 1);
    nb    = 16'(n);
    t0    = cyc;
    stop  = len;
    cut   = -1;
    if (abort_off >= 0) begin
      stop = abort_off + 1;
      cut  = abort_off;
      err_q.push_back(t0 + abort_off + 1);
    end
    if (reset_off >= 0) begin
      stop = reset_off + 1;
      cut  = reset_off;
    end
    for (int b = 0; b <= n; b++) begin
      e.cyc  = wr ? t0 + h + (b + 1) * dw : t0 + h + b;
      e.addr = (base + 16'(b)) & amask;
      e.data = wd[b];
      e.wr   = wr;
      e.last = (b == n);
      if (cut < 0 || e.cyc <= t0 + cut) exp_q.push_back(e);
    end
    for (int c = 0; c < stop; c++) begin
      mv  = 1'b1;
      ren = !wr;
      wen = wr;
      ra  = (c < aw) ? base[c] : 1'($urandom);
      rb  = (c < bw) ? nb[c] : 1'($urandom);
      rd  = 1'($urandom);
      if (wr && c >= h) begin
        k  = (c - h) / dw;
        j  = (c - h) % dw;
        rd = wd[k][j];
      end
      if (c == abort_off) mv = 1'b0;
      if (c == reset_off) reset = 1'b1;
      tick();
      if (c == 0) check_eq("ready_low", 32'(m_ready), 32'd0);
    end
    reset = 1'b0;
    mv    = 1'b0;
    ren   = 1'b0;
    wen   = 1'b0;
    if (reset_off >= 0) begin
      check_eq("rst_ready", 32'(m_ready), 32'd1);
      check_eq("rst_done", 32'(m_done), 32'd0);
      check_eq("rst_write", 32'(m_write), 32'd0);
      check_eq("rst_last", 32'(m_last), 32'd0);
      check_eq("rst_err", 32'(m_err), 32'd0);
      check_eq("rst_addr", 32'(m_addr), 32'd0);
      check_eq("rst_data", m_data, 32'd0);
    end else begin
      check_eq("ready_back", 32'(m_ready), 32'd1);
    end
  endtask

  task automatic select_cfg(input bit s);
    sel = s;
    aw  = s ? 16 : 12;
    dw  = s ? 32 : 8;
    bw  = s ? 4 : 8;
    #1;
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      select_cfg(s[0]);
      check_eq("reset_ready", 32'(m_ready), 32'd1);
      check_eq("reset_done", 32'(m_done), 32'd0);
      check_eq("reset_err", 32'(m_err), 32'd0);
      check_eq("reset_addr", 32'(m_addr), 32'd0);
      check_eq("reset_data", m_data, 32'd0);
    end
    select_cfg(1'b0);
    mon_en = 1'b1;
    tick();

    // Single write, burst with two beats, wrapping read burst.
    wd[0] = 32'h3C;
    do_txn(1'b1, 0, 16'hA5C, -1, -1);
    repeat (2) tick();
    wd[0] = 32'h11; wd[1] = 32'h22;
    do_txn(1'b1, 1, 16'h010, -1, -1);
    repeat (2) tick();
    do_txn(1'b0, 3, 16'hFFE, -1, -1);
    repeat (2) tick();

    // Abort in beat 1 of a three-beat write.
    wd[0] = 32'h5A; wd[1] = 32'hC3; wd[2] = 32'h77;
    do_txn(1'b1, 2, 16'h300, 24, -1);
    repeat (3) tick();

    // Back-to-back reads with no bubble.
    do_txn(1'b0, 0, 16'h123, -1, -1);
    do_txn(1'b0, 1, 16'h7F0, -1, -1);
    repeat (2) tick();

    // Illegal handshakes: both selects high, then both low.
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 4; c++) begin
        mv  = 1'b1;
        ren = (p == 0);
        wen = (p == 0);
        ra  = 1'($urandom);
        rb  = 1'($urandom);
        tick();
        check_eq("illegal_ready", 32'(m_ready), 32'd1);
      end
    end
    mv = 1'b0; ren = 1'b0; wen = 1'b0;
    repeat (3) tick();

    // Reset during the second write beat.
    wd[0] = 32'hE1; wd[1] = 32'h4B;
    do_txn(1'b1, 1, 16'h5A5, -1, 24);
    repeat (12) tick();

    // Wide configuration.
    select_cfg(1'b1);
    tick();
    wd[0] = 32'hDEADBEEF;
    do_txn(1'b1, 0, 16'hBEEF, -1, -1);
    repeat (2) tick();
    wd[0] = 32'h01234567; wd[1] = 32'h89ABCDEF;
    do_txn(1'b1, 1, 16'hFFFF, -1, -1);
    repeat (2) tick();
    do_txn(1'b0, 3, 16'hFFFE, -1, -1);
    repeat (20) tick();

    check_eq("beats_left", 32'(exp_q.size()), 32'd0);
    check_eq("errs_left", 32'(err_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
